// File: rtl/event_trace_player_pkg.sv
// Shared types and constants for the event trace player.
// Entry layout (MSB..LSB): delta | mask | channel data (lane k at k*DATA_W).
package event_trace_player_pkg;

    localparam int unsigned NUM_CH  = 3;
    localparam int unsigned DATA_W  = 64;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned DELTA_W = 32;

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned LVL_W   = PTR_W + 1;
    localparam int unsigned VAL_W   = NUM_CH * DATA_W;
    localparam int unsigned ENTRY_W = DELTA_W + NUM_CH + VAL_W;

    localparam int unsigned DATA_LSB  = 0;
    localparam int unsigned MASK_LSB  = VAL_W;
    localparam int unsigned DELTA_LSB = VAL_W + NUM_CH;

    typedef struct packed {
        logic [DELTA_W-1:0] delta;
        logic [NUM_CH-1:0]  mask;
        logic [VAL_W-1:0]   data;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        FIRE = 2'd2
    } state_t;

    // Build an entry from its fields using the documented bit offsets.
    function automatic entry_t pack_entry(input logic [DELTA_W-1:0] delta,
                                          input logic [NUM_CH-1:0]  mask,
                                          input logic [VAL_W-1:0]   data);
        logic [ENTRY_W-1:0] flat;
        flat = '0;
        flat[DELTA_LSB +: DELTA_W] = delta;
        flat[MASK_LSB  +: NUM_CH]  = mask;
        flat[DATA_LSB  +: VAL_W]   = data;
        return entry_t'(flat);
    endfunction

endpackage

// File: rtl/event_trace_player_if.sv
// Host/monitor-facing bundle of the event trace player.
//   write port : wr_valid/wr_ready handshake with wr_delta, wr_mask, wr_data
//   control    : en, start, stop, loop_mode
//   monitor    : in_value, in_new
//   status     : busy, done, level
interface event_trace_player_if;
    import event_trace_player_pkg::*;

    logic               en;
    logic               wr_valid;
    logic               wr_ready;
    logic [DELTA_W-1:0] wr_delta;
    logic [NUM_CH-1:0]  wr_mask;
    logic [VAL_W-1:0]   wr_data;
    logic               start;
    logic               stop;
    logic               loop_mode;
    logic [VAL_W-1:0]   in_value;
    logic [NUM_CH-1:0]  in_new;
    logic               busy;
    logic               done;
    logic [LVL_W-1:0]   level;

    modport master (
        output en, wr_valid, wr_delta, wr_mask, wr_data, start, stop, loop_mode,
        input  wr_ready, in_value, in_new, busy, done, level
    );

    modport slave (
        input  en, wr_valid, wr_delta, wr_mask, wr_data, start, stop, loop_mode,
        output wr_ready, in_value, in_new, busy, done, level
    );

endinterface

// File: rtl/event_trace_player_ram.sv
// Event buffer: DEPTH x entry_t circular store.
//   clk, rst      : clock, async active-low reset (empties the buffer)
//   wr_en_i       : append wr_entry_i at the write pointer
//   pop_i         : drop the oldest entry (one-shot consumption)
//   adv_i         : move the play pointer to the next entry, wrapping to the oldest
//   rewind_i      : return the play pointer to the oldest entry
//   head_o/next_o : entry at the play pointer and the one after it
//   level_o       : number of stored entries
module trace_entry_ram
    import event_trace_player_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  entry_t           wr_entry_i,
    input  logic             pop_i,
    input  logic             adv_i,
    input  logic             rewind_i,
    output entry_t           head_o,
    output entry_t           next_o,
    output logic [LVL_W-1:0] level_o
);

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] base_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic [PTR_W-1:0] rd_inc;
    logic [PTR_W-1:0] nxt_ptr;

    // The stored set is base..wr_ptr-1; stepping onto wr_ptr wraps to the oldest.
    always_comb begin
        rd_inc  = rd_ptr_q + PTR_W'(1);
        nxt_ptr = (rd_inc == wr_ptr_q) ? base_ptr_q : rd_inc;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign next_o  = mem_q[nxt_ptr];
    assign level_o = level_q;

    // Storage array, no reset needed: validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_ptr_q] <= wr_entry_i;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            base_ptr_q <= '0;
            level_q    <= '0;
        end else begin
            if (wr_en_i) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (rewind_i) begin
                rd_ptr_q <= base_ptr_q;
            end else if (pop_i) begin
                base_ptr_q <= base_ptr_q + PTR_W'(1);
                rd_ptr_q   <= rd_inc;
            end else if (adv_i) begin
                rd_ptr_q <= nxt_ptr;
            end
            level_q <= level_q + LVL_W'(wr_en_i) - LVL_W'(pop_i);
        end
    end

endmodule

// File: rtl/event_trace_player.sv
// Replays buffered timestamped events onto monitor input_k/new_input_k ports.
//   clk : single clock
//   rst : asynchronous active-low reset
//   bus : event_trace_player_if.slave (write port, control, monitor outputs, status)
module event_trace_player
    import event_trace_player_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    event_trace_player_if.slave  bus
);

    state_t             state_q, state_d;
    logic [DELTA_W-1:0] cnt_q, cnt_d;
    logic               loop_q, loop_d;
    logic               strobe_q, strobe_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               wr_ready_q, wr_ready_d;
    logic [NUM_CH-1:0]  in_new_q, in_new_d;
    logic [VAL_W-1:0]   in_value_q, in_value_d;

    logic               pop, adv, rewind, use_next, wr_en;
    logic [LVL_W-1:0]   level, level_d;
    entry_t             head, nxt, out_entry, wr_entry;

    assign wr_entry = pack_entry(bus.wr_delta, bus.wr_mask, bus.wr_data);

    trace_entry_ram u_ram (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (wr_en),
        .wr_entry_i (wr_entry),
        .pop_i      (pop),
        .adv_i      (adv),
        .rewind_i   (rewind),
        .head_o     (head),
        .next_o     (nxt),
        .level_o    (level)
    );

    // Playback FSM: gap countdown, strobe issue, advance/pop, stop and stall.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        loop_d   = loop_q;
        strobe_d = 1'b0;
        done_d   = 1'b0;
        pop      = 1'b0;
        adv      = 1'b0;
        rewind   = 1'b0;
        use_next = 1'b0;

        if (bus.en) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start && !bus.stop && (level != '0)) begin
                        loop_d = bus.loop_mode;
                        if (head.delta == '0) begin
                            state_d = FIRE;
                        end else begin
                            state_d = GAP;
                            cnt_d   = head.delta;
                        end
                    end
                end
                GAP: begin
                    if (bus.stop) begin
                        state_d = IDLE;
                        rewind  = 1'b1;
                    end else if (cnt_q == DELTA_W'(1)) begin
                        state_d = FIRE;
                    end else begin
                        cnt_d = cnt_q - DELTA_W'(1);
                    end
                end
                FIRE: begin
                    if (bus.stop) begin
                        state_d = IDLE;
                        rewind  = 1'b1;
                    end else if (!strobe_q) begin
                        // Strobe was suppressed by a stall: issue it again before advancing.
                        state_d = FIRE;
                    end else if (!loop_q && (level <= LVL_W'(1))) begin
                        pop     = 1'b1;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        pop      = !loop_q;
                        adv      = loop_q;
                        use_next = 1'b1;
                        if (nxt.delta == '0) begin
                            state_d = FIRE;
                        end else begin
                            state_d = GAP;
                            cnt_d   = nxt.delta;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
            strobe_d = (state_d == FIRE);
        end

        busy_d    = (state_d != IDLE);
        out_entry = use_next ? nxt : head;
        in_new_d  = strobe_d ? out_entry.mask : '0;
        in_value_d = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (strobe_d && out_entry.mask[k]) begin
                in_value_d[k*DATA_W +: DATA_W] = out_entry.data[k*DATA_W +: DATA_W];
            end
        end
    end

    // At full, readiness anticipates the pop of the strobe now on the outputs so a
    // streaming host keeps pace; if that pop is withdrawn (en low or stop) the write waits.
    assign wr_en      = bus.wr_valid && wr_ready_q && ((level != LVL_W'(DEPTH)) || pop);
    assign level_d    = level + LVL_W'(wr_en) - LVL_W'(pop);
    assign wr_ready_d = !(busy_d && loop_d)
                        && ((level_d < LVL_W'(DEPTH)) || (strobe_d && !loop_d));

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            loop_q     <= 1'b0;
            strobe_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_ready_q <= 1'b1;
            in_new_q   <= '0;
            in_value_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            loop_q     <= loop_d;
            strobe_q   <= strobe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wr_ready_q <= wr_ready_d;
            in_new_q   <= in_new_d;
            in_value_q <= in_value_d;
        end
    end

    assign bus.wr_ready = wr_ready_q;
    assign bus.in_new   = in_new_q;
    assign bus.in_value = in_value_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.level    = level;

endmodule

// File: tb/tb_event_trace_player.sv
// Directed, self-checking bench for event_trace_player.
module tb_event_trace_player;
    import event_trace_player_pkg::*;

    logic clk;
    logic rst;
    event_trace_player_if bus();

    event_trace_player dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // One-shot table: entry fields plus the hand-computed strobe cycle after start.
    typedef struct packed {
        int unsigned delta;
        logic [2:0]  mask;
        logic [63:0] val;
        int          cyc;
        int          grp;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [191:0] lanes(input logic [2:0] m, input logic [63:0] v);
        logic [191:0] r;
        r = '0;
        for (int k = 0; k < 3; k++) begin
            if (m[k]) r[k*64 +: 64] = v;
        end
        return r;
    endfunction

    // Offer one entry; called and returns at a falling edge.
    task automatic push(input logic [31:0] d, input logic [2:0] m, input logic [63:0] v);
        int n;
        n = 0;
        while (!bus.wr_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            n_checks++;
            n_err++;
            $display("FAIL push_timeout: wr_ready stayed %0b, needed 1", bus.wr_ready);
        end
        bus.wr_valid = 1'b1;
        bus.wr_delta = d;
        bus.wr_mask  = m;
        bus.wr_data  = {3{v}};
        tick();
        bus.wr_valid = 1'b0;
    endtask

    task automatic pulse_start(input logic lp);
        bus.start     = 1'b1;
        bus.loop_mode = lp;
        tick();
        bus.start     = 1'b0;
        bus.loop_mode = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
    endtask

    // Load one table group, start one-shot, and check every cycle up to n_cyc.
    task automatic run_table(input int grp, input int n_cyc, input int done_cyc);
        logic [2:0]   en_new;
        logic [191:0] en_val;
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].grp == grp) push(vecs[i].delta, vecs[i].mask, vecs[i].val);
        end
        pulse_start(1'b0);
        for (int off = 1; off <= n_cyc; off++) begin
            en_new = '0;
            en_val = '0;
            for (int i = 0; i < 6; i++) begin
                if (vecs[i].grp == grp && vecs[i].cyc == off) begin
                    en_new = vecs[i].mask;
                    en_val = lanes(vecs[i].mask, vecs[i].val);
                end
            end
            chk($sformatf("g%0d_in_new@%0d", grp, off), 192'(bus.in_new), 192'(en_new));
            chk($sformatf("g%0d_in_value@%0d", grp, off), bus.in_value, en_val);
            chk($sformatf("g%0d_busy@%0d", grp, off), 192'(bus.busy), 192'(off < done_cyc));
            chk($sformatf("g%0d_done@%0d", grp, off), 192'(bus.done), 192'(off == done_cyc));
            if (off == done_cyc) chk($sformatf("g%0d_level_end", grp), 192'(bus.level), 192'(0));
            tick();
        end
    endtask

    initial begin
        int nxt;
        int nine_seen;

        vecs[0] = '{delta: 0, mask: 3'b111, val: 64'd1, cyc: 1, grp: 0};
        vecs[1] = '{delta: 6, mask: 3'b111, val: 64'd2, cyc: 8, grp: 0};
        vecs[2] = '{delta: 0, mask: 3'b111, val: 64'd3, cyc: 9, grp: 0};
        vecs[3] = '{delta: 0, mask: 3'b110, val: 64'd6, cyc: 1, grp: 1};
        vecs[4] = '{delta: 4, mask: 3'b000, val: 64'd7, cyc: 6, grp: 1};
        vecs[5] = '{delta: 0, mask: 3'b011, val: 64'hFFFF_FFFF_FFFF_FFFB, cyc: 7, grp: 1};

        rst           = 1'b0;
        bus.en        = 1'b1;
        bus.wr_valid  = 1'b0;
        bus.wr_delta  = '0;
        bus.wr_mask   = '0;
        bus.wr_data   = '0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.loop_mode = 1'b0;

        tick();
        tick();
        chk("rst_in_value", bus.in_value, 192'(0));
        chk("rst_in_new", 192'(bus.in_new), 192'(0));
        chk("rst_wr_ready", 192'(bus.wr_ready), 192'(1));
        chk("rst_busy", 192'(bus.busy), 192'(0));
        chk("rst_done", 192'(bus.done), 192'(0));
        chk("rst_level", 192'(bus.level), 192'(0));
        rst = 1'b1;
        tick();

        // Start on an empty buffer is ignored.
        pulse_start(1'b0);
        chk("empty_start_busy", 192'(bus.busy), 192'(0));

        // Basic one-shot and partial-mask / pure-delay entries.
        run_table(0, 11, 10);
        run_table(1, 9, 8);

        // Loop mode: 1,2,1,2 every two cycles, no writes, stop rewinds.
        push(32'd1, 3'b111, 64'd1);
        push(32'd1, 3'b111, 64'd2);
        chk("loop_level_pre", 192'(bus.level), 192'(2));
        pulse_start(1'b1);
        for (int off = 1; off <= 8; off++) begin
            logic [2:0]  e_new;
            logic [63:0] e_v;
            e_new = (off % 2 == 0) ? 3'b111 : 3'b000;
            e_v   = (off % 2 == 1) ? 64'd0 : ((off % 4 == 2) ? 64'd1 : 64'd2);
            chk($sformatf("loop_in_new@%0d", off), 192'(bus.in_new), 192'(e_new));
            chk($sformatf("loop_lane0@%0d", off), 192'(bus.in_value[63:0]), 192'(e_v));
            chk($sformatf("loop_wr_ready@%0d", off), 192'(bus.wr_ready), 192'(0));
            chk($sformatf("loop_done@%0d", off), 192'(bus.done), 192'(0));
            if (off < 8) tick();
        end
        pulse_stop();
        chk("stop_in_new", 192'(bus.in_new), 192'(0));
        chk("stop_busy", 192'(bus.busy), 192'(0));
        chk("stop_done", 192'(bus.done), 192'(0));
        chk("stop_level", 192'(bus.level), 192'(2));
        chk("stop_wr_ready", 192'(bus.wr_ready), 192'(1));
        tick();
        chk("stop_done_after", 192'(bus.done), 192'(0));

        // Restart one-shot: rewound pointer plays the oldest entry first.
        pulse_start(1'b0);
        for (int off = 1; off <= 5; off++) begin
            logic [63:0] e_v;
            e_v = (off == 2) ? 64'd1 : ((off == 4) ? 64'd2 : 64'd0);
            chk($sformatf("rerun_lane0@%0d", off), 192'(bus.in_value[63:0]), 192'(e_v));
            chk($sformatf("rerun_done@%0d", off), 192'(bus.done), 192'(off == 5));
            tick();
        end
        chk("rerun_level", 192'(bus.level), 192'(0));

        // Full buffer, then one-shot playback streaming 24 more entries.
        for (int i = 1; i <= 16; i++) push(32'd0, 3'b111, 64'(i));
        chk("full_level", 192'(bus.level), 192'(16));
        chk("full_wr_ready", 192'(bus.wr_ready), 192'(0));
        pulse_start(1'b0);
        nxt = 17;
        for (int off = 1; off <= 42; off++) begin
            if (off <= 40) begin
                chk($sformatf("stream_in_new@%0d", off), 192'(bus.in_new), 192'(3'b111));
                chk($sformatf("stream_val@%0d", off), bus.in_value, {3{64'(off)}});
            end else begin
                chk($sformatf("stream_in_new@%0d", off), 192'(bus.in_new), 192'(0));
            end
            if (off <= 25) chk($sformatf("stream_level@%0d", off), 192'(bus.level), 192'(16));
            if (off == 41) begin
                chk("stream_done", 192'(bus.done), 192'(1));
                chk("stream_busy", 192'(bus.busy), 192'(0));
                chk("stream_level_end", 192'(bus.level), 192'(0));
            end
            if (nxt <= 40) begin
                bus.wr_valid = 1'b1;
                bus.wr_delta = 32'd0;
                bus.wr_mask  = 3'b111;
                bus.wr_data  = {3{64'(nxt)}};
                if (bus.wr_ready) nxt++;
            end else begin
                bus.wr_valid = 1'b0;
            end
            tick();
        end
        bus.wr_valid = 1'b0;
        chk("stream_all_written", 192'(nxt), 192'(41));

        // Enable stall right before the value-9 strobe.
        push(32'd0, 3'b111, 64'd8);
        push(32'd3, 3'b111, 64'd9);
        pulse_start(1'b0);
        nine_seen = 0;
        for (int off = 1; off <= 12; off++) begin
            logic [63:0] e_v;
            e_v = (off == 1) ? 64'd8 : ((off == 8) ? 64'd9 : 64'd0);
            chk($sformatf("stall_lane2@%0d", off), 192'(bus.in_value[191:128]), 192'(e_v));
            chk($sformatf("stall_done@%0d", off), 192'(bus.done), 192'(off == 9));
            if (bus.in_new == 3'b111 && bus.in_value[63:0] == 64'd9) nine_seen++;
            if (off == 4) bus.en = 1'b0;
            if (off == 7) bus.en = 1'b1;
            tick();
        end
        chk("stall_nine_once", 192'(nine_seen), 192'(1));

        // Reset in the middle of a gap.
        for (int i = 1; i <= 5; i++) push(32'd10, 3'b111, 64'(i));
        pulse_start(1'b0);
        tick();
        tick();
        chk("pre_rst_busy", 192'(bus.busy), 192'(1));
        chk("pre_rst_level", 192'(bus.level), 192'(5));
        rst = 1'b0;
        #1;
        chk("mid_rst_in_new", 192'(bus.in_new), 192'(0));
        chk("mid_rst_in_value", bus.in_value, 192'(0));
        chk("mid_rst_busy", 192'(bus.busy), 192'(0));
        chk("mid_rst_level", 192'(bus.level), 192'(0));
        chk("mid_rst_wr_ready", 192'(bus.wr_ready), 192'(1));
        tick();
        rst = 1'b1;
        tick();
        pulse_start(1'b0);
        for (int off = 1; off <= 4; off++) begin
            chk($sformatf("post_rst_busy@%0d", off), 192'(bus.busy), 192'(0));
            chk($sformatf("post_rst_in_new@%0d", off), 192'(bus.in_new), 192'(0));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
